// File: rtl/regbank_pkg.sv
// Shared types and width helpers for the banked register file.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COPY = 2'd1,
    DONE = 2'd2
  } copy_state_e;

  // Index widths never collapse to zero bits, even for degenerate sizes.
  function automatic int idx_w(input int reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/regbank_copy_fsm.sv
// Sequential bank-to-bank copy engine: one register beat per cycle,
// indices 1..REG_NUM-1, then a single-cycle done state.
module regbank_copy_fsm
  import regbank_pkg::*;
#(
  parameter  int REG_NUM   = 32,
  parameter  int NUM_BANKS = 2,
  localparam int AW        = idx_w(REG_NUM),
  localparam int BW        = bank_w(NUM_BANKS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          copy_valid,
  input  logic [BW-1:0] copy_src,
  input  logic [BW-1:0] copy_dst,
  output logic          copy_ready,
  output logic          copy_done,
  output logic          beat_en,
  output logic [AW-1:0] beat_idx,
  output logic [BW-1:0] beat_src,
  output logic [BW-1:0] beat_dst
);

  copy_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [BW-1:0] src_q, src_d;
  logic [BW-1:0] dst_q, dst_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    copy_ready = 1'b0;
    copy_done  = 1'b0;
    beat_en    = 1'b0;
    case (state_q)
      IDLE: begin
        copy_ready = 1'b1;
        if (copy_valid) begin
          src_d   = copy_src;
          dst_d   = copy_dst;
          idx_d   = AW'(1);
          state_d = COPY;
        end
      end
      COPY: begin
        beat_en = 1'b1;
        idx_d   = idx_q + AW'(1);
        if (idx_q == AW'(REG_NUM - 1)) state_d = DONE;
      end
      DONE: begin
        copy_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign beat_idx = idx_q;
  assign beat_src = src_q;
  assign beat_dst = dst_q;

endmodule

// File: rtl/register_bank_banked.sv
// Multi-bank, multi-read-port register file with a background copy engine.
// Optional REGBANK_BYPASS_EN: forward same-cycle write data to matching read ports.
module register_bank_banked
  import regbank_pkg::*;
#(
  parameter  int REG_NUM    = 32,
  parameter  int DATA_WIDTH = 64,
  parameter  int NUM_BANKS  = 2,
  parameter  int NUM_RD     = 2,
  localparam int AW         = idx_w(REG_NUM),
  localparam int BW         = bank_w(NUM_BANKS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [AW-1:0]                      write_addr,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               write_en,
  output logic                               write_ready,
  input  logic [NUM_RD-1:0][AW-1:0]          read_addr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]  data_out,
  input  logic                               switch_valid,
  input  logic [BW-1:0]                      switch_bank,
  input  logic                               copy_valid,
  input  logic [BW-1:0]                      copy_src,
  input  logic [BW-1:0]                      copy_dst,
  output logic                               copy_ready,
  output logic                               copy_done,
  output logic [BW-1:0]                      active_bank
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][REG_NUM];
  logic [BW-1:0]         active_q;

  logic          beat_en;
  logic [AW-1:0] beat_idx;
  logic [BW-1:0] beat_src, beat_dst;
  logic          wr_fire, sw_fire;

  regbank_copy_fsm #(
    .REG_NUM   (REG_NUM),
    .NUM_BANKS (NUM_BANKS)
  ) u_copy (
    .clk        (clk),
    .reset      (reset),
    .copy_valid (copy_valid),
    .copy_src   (copy_src),
    .copy_dst   (copy_dst),
    .copy_ready (copy_ready),
    .copy_done  (copy_done),
    .beat_en    (beat_en),
    .beat_idx   (beat_idx),
    .beat_src   (beat_src),
    .beat_dst   (beat_dst)
  );

  // Host writes and copy beats are mutually exclusive: host port only opens when idle.
  assign write_ready = copy_ready;
  assign wr_fire     = write_en && copy_ready && (write_addr != '0);
  assign sw_fire     = switch_valid && copy_ready && !copy_valid;
  assign active_bank = active_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < REG_NUM; r++)
          mem_q[b][r] <= '0;
      active_q <= '0;
    end else begin
      if (wr_fire) mem_q[active_q][write_addr] <= data_in;
      if (beat_en && (beat_idx != '0))
        mem_q[beat_dst][beat_idx] <= mem_q[beat_src][beat_idx];
      if (sw_fire) active_q <= switch_bank;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
`ifdef REGBANK_BYPASS_EN
    assign data_out[k] = (read_addr[k] == '0) ? '0 :
                         (wr_fire && (write_addr == read_addr[k])) ? data_in :
                         mem_q[active_q][read_addr[k]];
`else
    assign data_out[k] = (read_addr[k] == '0) ? '0 : mem_q[active_q][read_addr[k]];
`endif
  end

endmodule

// File: tb/tb_register_bank_banked.sv
// Scoreboard bench: per-cycle expectations from a bank/op-queue model, checked at negedge.
module tb_register_bank_banked;

  localparam int RN = 32;
  localparam int DW = 64;
  localparam int NB = 4;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int BW = 2;
  localparam int CW = NR * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset, write_en, switch_valid, copy_valid;
  logic [AW-1:0]          write_addr;
  logic [DW-1:0]          data_in;
  logic [NR-1:0][AW-1:0]  read_addr;
  logic [BW-1:0]          switch_bank, copy_src, copy_dst;
  logic                   write_ready, copy_ready, copy_done;
  logic [NR-1:0][DW-1:0]  data_out;
  logic [BW-1:0]          active_bank;

  register_bank_banked #(
    .REG_NUM(RN), .DATA_WIDTH(DW), .NUM_BANKS(NB), .NUM_RD(NR)
  ) dut (
    .clk(clk), .reset(reset),
    .write_addr(write_addr), .data_in(data_in), .write_en(write_en),
    .write_ready(write_ready), .read_addr(read_addr), .data_out(data_out),
    .switch_valid(switch_valid), .switch_bank(switch_bank),
    .copy_valid(copy_valid), .copy_src(copy_src), .copy_dst(copy_dst),
    .copy_ready(copy_ready), .copy_done(copy_done), .active_bank(active_bank)
  );

  typedef struct {
    logic [NR-1:0][DW-1:0] dout;
    logic                  rdy;
    logic                  done;
    logic [BW-1:0]         act;
    int                    cyc;
  } exp_t;

  // Pending copy work as a list of beats followed by one done marker.
  typedef struct {
    bit done;
    int idx;
    int src;
    int dst;
  } op_t;

  exp_t          sb[$];
  op_t           ops[$];
  logic [DW-1:0] mb [NB][RN];
  int            act;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;

  task automatic chk(input string nm, input int c, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, c, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < RN; r++)
        mb[b][r] = '0;
    ops.delete();
    act = 0;
  endtask

  task automatic step();
    exp_t e;
    op_t  o;
    e.rdy  = (ops.size() == 0);
    e.done = (ops.size() != 0) ? ops[0].done : 1'b0;
    e.act  = BW'(act);
    e.cyc  = cyc;
    for (int k = 0; k < NR; k++) begin
      int ra;
      ra = int'(read_addr[k]);
      e.dout[k] = (ra == 0) ? '0 : mb[act][ra];
`ifdef REGBANK_BYPASS_EN
      if (e.rdy && write_en && write_addr != '0 && write_addr == read_addr[k])
        e.dout[k] = data_in;
`endif
    end
    sb.push_back(e);
    if (reset) begin
      model_clear();
    end else if (!e.rdy) begin
      o = ops.pop_front();
      if (!o.done) mb[o.dst][o.idx] = mb[o.src][o.idx];
    end else begin
      if (write_en && write_addr != '0) mb[act][int'(write_addr)] = data_in;
      if (copy_valid) begin
        for (int i = 1; i < RN; i++)
          ops.push_back('{1'b0, i, int'(copy_src), int'(copy_dst)});
        ops.push_back('{1'b1, 0, 0, 0});
      end else if (switch_valid) begin
        act = int'(switch_bank);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    reset        = 1'b0;
    write_en     = 1'b0;
    switch_valid = 1'b0;
    copy_valid   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t m;
      m = sb.pop_front();
      chk("data_out",    m.cyc, CW'(data_out),    CW'(m.dout));
      chk("copy_ready",  m.cyc, CW'(copy_ready),  CW'(m.rdy));
      chk("write_ready", m.cyc, CW'(write_ready), CW'(m.rdy));
      chk("copy_done",   m.cyc, CW'(copy_done),   CW'(m.done));
      chk("active_bank", m.cyc, CW'(active_bank), CW'(m.act));
    end
  end

  initial begin
    clr();
    reset       = 1'b1;
    write_addr  = '0;
    data_in     = '0;
    read_addr   = '0;
    switch_bank = '0;
    copy_src    = '0;
    copy_dst    = '0;
    model_clear();
    @(posedge clk);
    #1;
    step();
    reset = 1'b0;

    // Reset contents on every index.
    for (int i = 0; i < RN; i++) begin
      read_addr[0] = AW'(i);
      read_addr[1] = AW'(RN - 1 - i);
      step();
    end

    // Bank isolation and register 0.
    write_en = 1'b1; write_addr = 5; data_in = 64'hDEAD_BEEF; step();
    clr(); switch_valid = 1'b1; switch_bank = 1; read_addr[0] = 5; step();
    clr(); step();
    switch_valid = 1'b1; switch_bank = 0; step();
    clr(); step();
    write_en = 1'b1; write_addr = 0; data_in = 64'h1; read_addr[1] = 0; step();
    clr(); step();

    // Fill bank0, copy 0 -> 1, hammer write/switch while busy.
    for (int i = 1; i < RN; i++) begin
      write_en = 1'b1; write_addr = AW'(i); data_in = DW'(i); step();
    end
    clr();
    copy_valid = 1'b1; copy_src = 0; copy_dst = 1; step();
    clr();
    for (int i = 0; i < RN + 2; i++) begin
      write_en     = 1'($urandom_range(0, 1));
      write_addr   = AW'($urandom_range(1, RN - 1));
      data_in      = {$urandom, $urandom};
      switch_valid = 1'($urandom_range(0, 1));
      switch_bank  = BW'($urandom_range(0, NB - 1));
      read_addr[0] = AW'($urandom_range(0, RN - 1));
      read_addr[1] = AW'($urandom_range(0, RN - 1));
      step();
    end
    clr();
    switch_valid = 1'b1; switch_bank = 1; step();
    clr();
    for (int i = 0; i < RN; i++) begin
      read_addr[0] = AW'(i); read_addr[1] = AW'((i + 7) % RN); step();
    end

    // Copy wins over same-cycle switch; then reset on cycle 10 of the copy.
    copy_valid = 1'b1; switch_valid = 1'b1; switch_bank = 2; copy_src = 1; copy_dst = 3; step();
    clr();
    repeat (9) step();
    reset = 1'b1; step();
    clr();
    for (int i = 0; i < 4; i++) begin
      read_addr[0] = AW'(i + 1); read_addr[1] = AW'(i + 20); step();
    end

    // Same-cycle read of a register being written.
    write_en = 1'b1; write_addr = 7; data_in = 64'h11; step();
    write_en = 1'b1; write_addr = 7; data_in = 64'h55; read_addr[1] = 7; read_addr[0] = 7; step();
    clr(); step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      write_en     = 1'($urandom_range(0, 1));
      write_addr   = AW'($urandom_range(0, RN - 1));
      data_in      = {$urandom, $urandom};
      switch_valid = ($urandom_range(0, 7) == 0);
      switch_bank  = BW'($urandom_range(0, NB - 1));
      copy_valid   = ($urandom_range(0, 39) == 0);
      copy_src     = BW'($urandom_range(0, NB - 1));
      copy_dst     = BW'($urandom_range(0, NB - 1));
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 3) == 0) read_addr[k] = write_addr;
        else read_addr[k] = AW'($urandom_range(0, RN - 1));
      end
      step();
    end
    clr();
    step();

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_banked.md
Name: register_bank_banked

Overview:
Parametrised multi-bank, multi-read-port register file; successor to the single-bank shadow register stub.
- Holds NUM_BANKS complete register sets, one of them "active".
- Serves NUM_RD combinational read ports and one write port against the active bank.
- Contains a sequential copy engine that snapshots one bank into another, one register per cycle, for context save/restore (interrupt/trap shadowing).

Parameters:
- REG_NUM, 32: registers per bank; power of two, >=2; register 0 hardwired zero in every bank.
- DATA_WIDTH, 64: register width in bits.
- NUM_BANKS, 2: number of register sets; power of two, >=2.
- NUM_RD, 2: number of read ports; >=1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- write_addr  in  $clog2(REG_NUM)  write register index.
- data_in  in  DATA_WIDTH  write data.
- write_en  in  1  write request.
- write_ready  out  1  write accepted this cycle; equals copy_ready.
- read_addr  in  NUM_RD*$clog2(REG_NUM)  packed read indices; port k in slice k.
- data_out  out  NUM_RD*DATA_WIDTH  packed read data, combinational from the active bank.
- switch_valid  in  1  request to change the active bank.
- switch_bank  in  $clog2(NUM_BANKS)  target active bank.
- copy_valid  in  1  request a bank-to-bank copy.
- copy_src  in  $clog2(NUM_BANKS)  source bank.
- copy_dst  in  $clog2(NUM_BANKS)  destination bank.
- copy_ready  out  1  engine idle; switch/copy/write accepted.
- copy_done  out  1  one-cycle pulse when a copy finishes.
- active_bank  out  $clog2(NUM_BANKS)  current active bank.

Behaviour:
- Reset: all registers in all banks = 0; active_bank=0; FSM=IDLE; copy_ready=1 (combinational from FSM); copy_done=0.
  - Reset mid-copy aborts the copy immediately, with no copy_done pulse.
- Reads:
  - data_out[k] = active_bank[read_addr[k]], combinational.
  - Index 0 always returns 0.
- Write: when write_en && write_ready && write_addr!=0, active_bank[write_addr] <= data_in at posedge.
  - Writes with write_ready=0 are dropped; the requester holds.
- Switch: accepted when switch_valid && copy_ready && !copy_valid; active_bank <= switch_bank at posedge.
  - A write in the same cycle goes to the old bank.
  - Reads see the new bank from the next cycle.
- Copy FSM, states IDLE, COPY, DONE:
  - IDLE: copy_valid latches src/dst, idx<=1, next state COPY. Copy has priority over a same-cycle switch, which is ignored.
  - COPY: dst[idx] <= src[idx] each cycle, idx++. After idx==REG_NUM-1, next state DONE.
  - DONE: copy_done=1 for one cycle, next state IDLE.
  - copy_ready=0 in COPY and DONE; copy_done=1 only in DONE.
  - Timing: accept on edge 0; COPY runs REG_NUM-1 cycles; copy_done high in cycle REG_NUM; copy_ready=1 again in cycle REG_NUM+1.
  - A write accepted in the same cycle as the copy is committed before the first copy beat, so it is included in the snapshot.
  - copy_src==copy_dst: runs the full duration; contents unchanged.
  - copy_dst may equal active_bank; reads during the copy observe partially-copied data (caller's responsibility).
- Register 0 of every bank is never written, including by the copy engine.

Optional Feature:
- REGBANK_BYPASS_EN defined: same-cycle forwarding. If write_en && write_ready && write_addr==read_addr[k] && write_addr!=0, then data_out[k]=data_in.
- Not defined: data_out returns the stored (pre-write) value until the next cycle.

Decomposition:
- Package regbank_pkg:
  - copy FSM state enum (IDLE/COPY/DONE);
  - localparam helper functions for address and bank index widths.
- Sub-module regbank_copy_fsm:
  - owns state, idx, latched src/dst;
  - outputs copy_ready, copy_done, copy beat enable and index.
- The top module holds the storage array, read muxes and write/copy write-port arbitration.

Test Plan:
- Reset then read all ports at indices 0..31 -> all 0; active_bank=0; copy_ready=1; copy_done=0.
- Write reg5=0xDEAD_BEEF in bank0; switch to bank1; read reg5 -> 0; switch back to bank0 -> 0xDEAD_BEEF. Write reg0=0x1 -> reads 0.
- Fill bank0 regs 1..31 with value i; copy 0->1 (REG_NUM=32):
  - copy_ready=0 for 32 cycles;
  - copy_done pulses exactly once, 32 cycles after accept;
  - bank1 regs 1..31 = i.
- During a copy, assert write_en and switch_valid -> write_ready=0; write dropped; active_bank unchanged. Same-cycle copy_valid+switch_valid -> copy starts, switch ignored.
- Assert reset at cycle 10 of a copy -> no copy_done; all banks 0; copy_ready=1 the next cycle.
- With REGBANK_BYPASS_EN: write reg7=0x55 while read_addr[1]=7 -> data_out[1]=0x55 the same cycle. Without it -> the old value, then 0x55 the next cycle.
